// File: rtl/simd_exec_stage.sv
// -----------------------------------------------------------------------------
// simd_exec_stage
//   Execute stage fed by the decode-stage register file. Applies one lane-wise
//   SIMD ALU operation per accepted instruction and holds the result until
//   writeback takes it. Non-MUL ops complete on the accept edge (latency 1);
//   MUL walks the lanes one per cycle through a single shared multiplier.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   flush             synchronous kill of the in-flight op and pending output
//   inValid/inReady   upstream instruction handshake
//   aluOp             ADD SUB AND OR XOR SLL MUL PASS2 (000..111)
//   isVector, wrEn    destination kind / instruction writes a register
//   destReg           destination register index
//   operand1/2        lane-packed sources (lane0 in the low bits)
//   outValid/outReady result handshake towards writeback
//   result            lane-packed result, feeds the register-file dataIn
//   regToWrite        captured destReg
//   regWrEnSc/Vec     one-cycle write strobes on the result handshake
//   busy              a multi-cycle MUL is in progress
// -----------------------------------------------------------------------------
module simd_exec_stage #(
  parameter int regSize    = 16,
  parameter int vectorSize = 4,
  parameter int selBits    = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         inValid,
  output logic                         inReady,
  input  logic [2:0]                   aluOp,
  input  logic                         isVector,
  input  logic                         wrEn,
  input  logic [selBits-1:0]           destReg,
  input  logic [vectorSize*regSize-1:0] operand1,
  input  logic [vectorSize*regSize-1:0] operand2,
  output logic                         outValid,
  input  logic                         outReady,
  output logic [vectorSize*regSize-1:0] result,
  output logic [selBits-1:0]           regToWrite,
  output logic                         regWrEnSc,
  output logic                         regWrEnVec,
  output logic                         busy
);

  localparam int W  = vectorSize * regSize;
  localparam int SH = $clog2(regSize);
  localparam int LW = (vectorSize > 1) ? $clog2(vectorSize) : 1;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR    = 3'b011,
    OP_XOR = 3'b100, OP_SLL = 3'b101, OP_MUL = 3'b110, OP_PASS2 = 3'b111
  } alu_op_e;

  typedef enum logic {ST_IDLE, ST_MUL} state_e;

  state_e            state_q, state_d;
  logic [LW-1:0]     lane_idx;
  logic [W-1:0]      op_a_q, op_b_q;
  logic              wr_en_q, is_vec_q;
  logic              accept, drain, last_lane;
  logic [regSize-1:0] mul_a, mul_b, mul_lo;

  // Single-cycle lane-wise ALU. MUL is excluded here so only the shared
  // multiplier below exists.
  function automatic logic [W-1:0] alu_vec(input logic [2:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [regSize-1:0] la, lb, lr;
    alu_vec = '0;
    for (int i = 0; i < vectorSize; i++) begin
      la = a[i*regSize +: regSize];
      lb = b[i*regSize +: regSize];
      case (op)
        OP_ADD:   lr = la + lb;
        OP_SUB:   lr = la - lb;
        OP_AND:   lr = la & lb;
        OP_OR:    lr = la | lb;
        OP_XOR:   lr = la ^ lb;
        OP_SLL:   lr = la << lb[SH-1:0];
        OP_PASS2: lr = lb;
        default:  lr = '0;
      endcase
      alu_vec[i*regSize +: regSize] = lr;
    end
  endfunction

  assign accept    = inValid & inReady;
  // A flush cycle never counts as a handshake, so no register write leaks out.
  assign drain     = outValid & outReady & ~flush;
  assign last_lane = (lane_idx == LW'(vectorSize - 1));

  assign mul_a  = op_a_q[lane_idx*regSize +: regSize];
  assign mul_b  = op_b_q[lane_idx*regSize +: regSize];
  assign mul_lo = mul_a * mul_b;   // low regSize bits of the unsigned product

  assign regWrEnSc  = drain & wr_en_q & ~is_vec_q;
  assign regWrEnVec = drain & wr_en_q &  is_vec_q;

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: default assignment first keeps this combinational block latch-free.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (accept && aluOp == OP_MUL) state_d = ST_MUL;
        ST_MUL:  if (last_lane)                 state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy    = (state_q == ST_MUL);
    inReady = (state_q == ST_IDLE) & ~flush & (~outValid | outReady);
  end

  // ---------------- Datapath / output register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outValid   <= 1'b0;
      result     <= '0;
      regToWrite <= '0;
      lane_idx   <= '0;
      wr_en_q    <= 1'b0;
      is_vec_q   <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
    end else if (flush) begin
      outValid <= 1'b0;
      lane_idx <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            wr_en_q    <= wrEn;
            is_vec_q   <= isVector;
            regToWrite <= destReg;
            op_a_q     <= operand1;
            op_b_q     <= operand2;
            lane_idx   <= '0;
            if (aluOp == OP_MUL) begin
              // Accept implies the old result drained this cycle.
              outValid <= 1'b0;
            end else begin
              result   <= alu_vec(aluOp, operand1, operand2);
              outValid <= 1'b1;
            end
          end else if (drain) begin
            outValid <= 1'b0;
          end
        end
        ST_MUL: begin
          result[lane_idx*regSize +: regSize] <= mul_lo;
          lane_idx <= last_lane ? '0 : lane_idx + 1'b1;
          if (last_lane) outValid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_simd_exec_stage
//   Self-checking bench for simd_exec_stage (regSize=16, vectorSize=4).
//   A vector table drives every ALU op; hand sequences cover MUL latency,
//   output hold, flush, asynchronous reset mid-MUL and back-to-back streaming.
//   Expected results are queued on accept and compared on the result handshake.
// -----------------------------------------------------------------------------
module tb_simd_exec_stage;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                         XOR_ = 3'b100, SLL = 3'b101, MUL = 3'b110, PASS2 = 3'b111;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [2:0]  aluOp = '0;
  logic        isVector = 1'b0;
  logic        wrEn = 1'b0;
  logic [1:0]  destReg = '0;
  logic [63:0] operand1 = '0;
  logic [63:0] operand2 = '0;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [63:0] result;
  logic [1:0]  regToWrite;
  logic        regWrEnSc, regWrEnVec, busy;

  simd_exec_stage #(.regSize(16), .vectorSize(4), .selBits(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .inValid(inValid), .inReady(inReady),
    .aluOp(aluOp), .isVector(isVector), .wrEn(wrEn), .destReg(destReg),
    .operand1(operand1), .operand2(operand2),
    .outValid(outValid), .outReady(outReady),
    .result(result), .regToWrite(regToWrite),
    .regWrEnSc(regWrEnSc), .regWrEnVec(regWrEnVec), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        is_vec;
    logic        we;
    logic [1:0]  dest;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic [1:0]  dest;
    logic        vec_we;
    logic        sc_we;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   vec_pulses = 0;
  int   sc_pulses  = 0;

  function automatic logic [63:0] pack4(input logic [15:0] l0, input logic [15:0] l1,
                                        input logic [15:0] l2, input logic [15:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result monitor: a handshake happens on the next edge when outValid &
  // outReady & ~flush are seen here, half a cycle before it.
  always @(negedge clk) begin
    if (reset) begin
      if (outValid && outReady && !flush) begin
        check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("result", result, e.res);
          check("regToWrite", 64'(regToWrite), 64'(e.dest));
          check("regWrEnVec", 64'(regWrEnVec), 64'(e.vec_we));
          check("regWrEnSc", 64'(regWrEnSc), 64'(e.sc_we));
        end
      end else begin
        check("wren_idle", 64'({regWrEnVec, regWrEnSc}), 64'd0);
      end
      if (regWrEnVec) vec_pulses++;
      if (regWrEnSc)  sc_pulses++;
    end
  end

  task automatic drive(input logic [2:0] op, input logic vec, input logic we,
                       input logic [1:0] dest, input logic [63:0] a, input logic [63:0] b);
    inValid  = 1'b1;
    aluOp    = op;
    isVector = vec;
    wrEn     = we;
    destReg  = dest;
    operand1 = a;
    operand2 = b;
  endtask

  task automatic push_exp(input logic [63:0] res, input logic [1:0] dest,
                          input logic vec, input logic we);
    exp_t e;
    e.res = res; e.dest = dest; e.vec_we = we & vec; e.sc_we = we & ~vec;
    sb.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [2:0] op, input logic vec, input logic we,
                      input logic [1:0] dest, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] exp, output int waits);
    bit ok = 0;
    waits = 0;
    drive(op, vec, we, dest, a, b);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (inReady) begin
        push_exp(exp, dest, vec, we);
        ok = 1;
        break;
      end
      waits++;
    end
    if (!ok) check("send_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !outValid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[10];
    int   w, total_w, p0, s0;
    logic [63:0] a, b;

    tbl[0] = '{ADD,   1, 1, 2'd1, pack4(16'h0001, 16'h0002, 16'h0003, 16'hFFFF),
                                  pack4(16'h0001, 16'h0001, 16'h0001, 16'h0001),
                                  pack4(16'h0002, 16'h0003, 16'h0004, 16'h0000)};
    tbl[1] = '{SUB,   1, 1, 2'd2, pack4(16'h0005, 16'h0000, 16'h000A, 16'h8000),
                                  pack4(16'h0003, 16'h0001, 16'h000A, 16'h0001),
                                  pack4(16'h0002, 16'hFFFF, 16'h0000, 16'h7FFF)};
    tbl[2] = '{AND_,  1, 1, 2'd3, pack4(16'hF0F0, 16'hFFFF, 16'h1234, 16'h0000),
                                  pack4(16'hFF00, 16'h0F0F, 16'h00FF, 16'hFFFF),
                                  pack4(16'hF000, 16'h0F0F, 16'h0034, 16'h0000)};
    tbl[3] = '{OR_,   1, 1, 2'd0, pack4(16'hF0F0, 16'h0000, 16'h1200, 16'h8000),
                                  pack4(16'h0F0F, 16'h0000, 16'h0034, 16'h0001),
                                  pack4(16'hFFFF, 16'h0000, 16'h1234, 16'h8001)};
    tbl[4] = '{XOR_,  1, 1, 2'd1, pack4(16'hFFFF, 16'hAAAA, 16'h1234, 16'h0000),
                                  pack4(16'hFFFF, 16'h5555, 16'h1234, 16'h0001),
                                  pack4(16'h0000, 16'hFFFF, 16'h0000, 16'h0001)};
    tbl[5] = '{SLL,   1, 1, 2'd2, pack4(16'h0001, 16'h0001, 16'h8001, 16'hFFFF),
                                  pack4(16'h0000, 16'h000F, 16'h0001, 16'h0014),
                                  pack4(16'h0001, 16'h8000, 16'h0002, 16'hFFF0)};
    tbl[6] = '{PASS2, 0, 1, 2'd3, pack4(16'h0001, 16'h0002, 16'h0003, 16'h0004),
                                  pack4(16'h0009, 16'h0008, 16'h0007, 16'h0006),
                                  pack4(16'h0009, 16'h0008, 16'h0007, 16'h0006)};
    tbl[7] = '{MUL,   1, 1, 2'd1, pack4(16'h0002, 16'h0003, 16'h0004, 16'h0005),
                                  pack4(16'h0007, 16'h0007, 16'h0007, 16'h4000),
                                  pack4(16'h000E, 16'h0015, 16'h001C, 16'h4000)};
    tbl[8] = '{MUL,   0, 1, 2'd2, pack4(16'hFFFF, 16'h0100, 16'h0000, 16'h0003),
                                  pack4(16'hFFFF, 16'h0100, 16'h1234, 16'h5555),
                                  pack4(16'h0001, 16'h0000, 16'h0000, 16'hFFFF)};
    tbl[9] = '{ADD,   1, 0, 2'd3, pack4(16'h0001, 16'h0001, 16'h0001, 16'h0001),
                                  pack4(16'h0001, 16'h0001, 16'h0001, 16'h0001),
                                  pack4(16'h0002, 16'h0002, 16'h0002, 16'h0002)};

    // ---- reset state ----
    #12;
    check("rst_outValid", 64'(outValid), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_regToWrite", 64'(regToWrite), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wren", 64'({regWrEnVec, regWrEnSc}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // ---- table: every op, outReady held high ----
    outReady = 1'b1;
    for (int i = 0; i < 10; i++)
      send(tbl[i].op, tbl[i].is_vec, tbl[i].we, tbl[i].dest, tbl[i].a, tbl[i].b, tbl[i].exp, w);
    wait_drain();

    // ---- MUL latency: inReady low for 4 cycles, then result ----
    drive(MUL, 1, 1, 2'd2, tbl[7].a, tbl[7].b);
    @(negedge clk);
    check("mul_accept_ready", 64'(inReady), 64'd1);
    push_exp(tbl[7].exp, 2'd2, 1, 1);
    @(posedge clk); #1;
    inValid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("mul_busy", 64'(busy), 64'd1);
      check("mul_inReady", 64'(inReady), 64'd0);
      check("mul_outValid_low", 64'(outValid), 64'd0);
    end
    @(negedge clk);
    check("mul_done_busy", 64'(busy), 64'd0);
    check("mul_done_valid", 64'(outValid), 64'd1);
    wait_drain();

    // ---- scalar SUB held by outReady=0 for 3 cycles ----
    outReady = 1'b0;
    s0 = sc_pulses;
    send(SUB, 0, 1, 2'd2, {4{16'd5}}, {4{16'd5}}, 64'd0, w);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_valid", 64'(outValid), 64'd1);
      check("hold_result", result, 64'd0);
      check("hold_regToWrite", 64'(regToWrite), 64'd2);
      check("hold_inReady", 64'(inReady), 64'd0);
      @(posedge clk); #1;
    end
    outReady = 1'b1;
    wait_drain();
    check("hold_single_sc_pulse", 64'(sc_pulses - s0), 64'd1);

    // ---- flush on cycle 2 of a MUL ----
    p0 = vec_pulses;
    drive(MUL, 1, 1, 2'd3, tbl[7].a, tbl[7].b);
    @(negedge clk);
    check("fl_accept_ready", 64'(inReady), 64'd1);
    @(posedge clk); #1;
    inValid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("fl_busy_before", 64'(busy), 64'd1);
    check("fl_inReady", 64'(inReady), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("fl_outValid", 64'(outValid), 64'd0);
      check("fl_busy", 64'(busy), 64'd0);
    end
    check("fl_no_write", 64'(vec_pulses - p0), 64'd0);
    @(posedge clk); #1;
    send(ADD, 1, 1, 2'd1, tbl[0].a, tbl[0].b, tbl[0].exp, w);
    wait_drain();
    check("fl_next_add_write", 64'(vec_pulses - p0), 64'd1);

    // ---- flush over a pending result with outReady=1: no write ----
    outReady = 1'b0;
    p0 = vec_pulses;
    send(XOR_, 1, 1, 2'd0, tbl[4].a, tbl[4].b, tbl[4].exp, w);
    flush = 1'b1;
    outReady = 1'b1;
    @(negedge clk);
    check("flp_wren", 64'({regWrEnVec, regWrEnSc}), 64'd0);
    check("flp_inReady", 64'(inReady), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flp_outValid", 64'(outValid), 64'd0);
    check("flp_no_write", 64'(vec_pulses - p0), 64'd0);
    @(posedge clk); #1;

    // ---- asynchronous reset in the middle of a MUL ----
    drive(MUL, 1, 1, 2'd3, tbl[7].a, tbl[7].b);
    @(negedge clk);
    check("rm_accept_ready", 64'(inReady), 64'd1);
    @(posedge clk); #1;
    inValid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("rm_outValid", 64'(outValid), 64'd0);
    check("rm_result", result, 64'd0);
    check("rm_regToWrite", 64'(regToWrite), 64'd0);
    check("rm_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rm_idle_after", 64'(busy), 64'd0);
    check("rm_no_valid_after", 64'(outValid), 64'd0);
    @(posedge clk); #1;
    send(SLL, 1, 1, 2'd2, tbl[5].a, tbl[5].b, tbl[5].exp, w);
    wait_drain();

    // ---- streaming: 8 XOR back-to-back, no bubbles ----
    p0 = vec_pulses;
    total_w = 0;
    for (int i = 0; i < 8; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      send(XOR_, 1, 1, 2'(i), a, b, a ^ b, w);
      if (i > 0) total_w += w;
    end
    wait_drain();
    check("stream_no_bubbles", 64'(total_w), 64'd0);
    check("stream_vec_pulses", 64'(vec_pulses - p0), 64'd8);

    check("sb_empty_at_end", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
